// File: rtl/spu_result_reducer_if.sv
// Handshake bundle for the result reducer: the sample stream in, the summary
// stream out, and the busy status.
interface spu_result_reducer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  // The reducer itself is the slave. The environment that drives samples and
  // drains frames is the master.
  modport slave (
    input  in_valid, in_data, in_op, flush, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, in_op, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/spu_result_reducer.sv
// Accumulates sum/min/max over a window of 2^LOG2_WIN result bytes, then emits
// a 6-byte summary frame (header, sum hi, sum lo, min, max, mean).
module spu_result_reducer #(
  parameter int LOG2_WIN = 3
) (
  input  logic                clk,
  input  logic                reset,
  spu_result_reducer_if.slave bus
);

  typedef enum logic {ACCUM, EMIT} state_t;

  localparam logic [4:0] WIN = 5'(1 << LOG2_WIN);

  state_t      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  max_q, max_d;
  logic [1:0]  op_q, op_d;
  logic        mixed_q, mixed_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  beat_q, beat_d;
  logic [7:0]  out_data_w;
  logic        accept;
  logic        first;

  assign accept = bus.in_valid && (state_q == ACCUM);
  assign first  = (count_q == 5'd0);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    op_d    = op_q;
    mixed_d = mixed_q;
    count_d = count_q;
    beat_d  = beat_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          sum_d   = sum_q + {8'd0, bus.in_data};
          count_d = count_q + 5'd1;
          if (first) begin
            min_d = bus.in_data;
            max_d = bus.in_data;
            op_d  = bus.in_op;
          end else begin
            min_d   = (bus.in_data < min_q) ? bus.in_data : min_q;
            max_d   = (bus.in_data > max_q) ? bus.in_data : max_q;
            mixed_d = mixed_q || (bus.in_op != op_q);
          end
        end
        // A flush closes the window only if it holds at least one sample,
        // counting one accepted in the same cycle.
        if ((accept && (count_d == WIN)) || (bus.flush && (count_d != 5'd0))) begin
          state_d = EMIT;
          beat_d  = 3'd0;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (beat_q == 3'd5) begin
            state_d = ACCUM;
            sum_d   = 16'd0;
            count_d = 5'd0;
            mixed_d = 1'b0;
            beat_d  = 3'd0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      sum_q   <= 16'd0;
      min_q   <= 8'd0;
      max_q   <= 8'd0;
      op_q    <= 2'd0;
      mixed_q <= 1'b0;
      count_q <= 5'd0;
      beat_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      op_q    <= op_d;
      mixed_q <= mixed_d;
      count_q <= count_d;
      beat_q  <= beat_d;
    end
  end

  // The mean always uses the full-window shift; partial windows show up in count.
  always_comb begin
    out_data_w = 8'h00;
    if (state_q == EMIT) begin
      case (beat_q)
        3'd0:    out_data_w = {op_q, mixed_q, count_q};
        3'd1:    out_data_w = sum_q[15:8];
        3'd2:    out_data_w = sum_q[7:0];
        3'd3:    out_data_w = min_q;
        3'd4:    out_data_w = max_q;
        3'd5:    out_data_w = 8'(sum_q >> LOG2_WIN);
        default: out_data_w = 8'h00;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACCUM) && !reset;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = out_data_w;
  assign bus.out_last  = (state_q == EMIT) && (beat_q == 3'd5);
  assign bus.busy      = (state_q == EMIT) || (count_q != 5'd0);

endmodule

// File: tb/tb_spu_result_reducer.sv
// Self-checking bench for spu_result_reducer: directed frames from the test plan
// plus randomized traffic, all compared against a queue-based window model.
module tb_spu_result_reducer;

  localparam int LOG2_WIN = 3;
  localparam int WIN      = 1 << LOG2_WIN;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spu_result_reducer_if bus_if ();

  spu_result_reducer #(.LOG2_WIN(LOG2_WIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Model state: samples of the open window, and the beats still to be emitted.
  logic [7:0]  win_data[$];
  logic [1:0]  win_op[$];
  logic [7:0]  exp_q[$];
  logic [47:0] last_frame;
  logic [47:0] dut_frame;
  int          n_checks;
  int          n_fail;

  function automatic void check(string name, logic [47:0] act, logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Builds the frame from the collected window with plain arithmetic.
  function automatic void build_frame();
    int         sum;
    int         mn;
    int         mx;
    bit         mixed;
    logic [7:0] hdr;
    logic [7:0] mean;
    sum   = 0;
    mn    = 255;
    mx    = 0;
    mixed = 1'b0;
    foreach (win_data[i]) begin
      sum += int'(win_data[i]);
      if (int'(win_data[i]) < mn) mn = int'(win_data[i]);
      if (int'(win_data[i]) > mx) mx = int'(win_data[i]);
      if (win_op[i] != win_op[0]) mixed = 1'b1;
    end
    hdr  = {win_op[0], mixed, 5'(win_data.size())};
    mean = 8'(sum / WIN);
    last_frame = {hdr, 8'(sum / 256), 8'(sum % 256), 8'(mn), 8'(mx), mean};
    for (int b = 5; b >= 0; b--) exp_q.push_back(last_frame[b*8 +: 8]);
    win_data.delete();
    win_op.delete();
  endfunction

  function automatic void model_step(bit v, logic [7:0] d, logic [1:0] op,
                                     bit fl, bit ordy, bit rst);
    if (rst) begin
      win_data.delete();
      win_op.delete();
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (ordy) void'(exp_q.pop_front());
    end else begin
      if (v) begin
        win_data.push_back(d);
        win_op.push_back(op);
      end
      if ((v && win_data.size() == WIN) || (fl && win_data.size() > 0)) build_frame();
    end
  endfunction

  task automatic checkOutput();
    bit emit;
    emit = (exp_q.size() != 0);
    check("in_ready", bus_if.in_ready, !reset && !emit);
    check("out_valid", bus_if.out_valid, emit);
    check("busy", bus_if.busy, emit || (win_data.size() != 0));
    if (reset) begin
      check("out_data_rst", bus_if.out_data, 8'h00);
      check("out_last_rst", bus_if.out_last, 1'b0);
    end else if (emit) begin
      check("out_data", bus_if.out_data, exp_q[0]);
      check("out_last", bus_if.out_last, exp_q.size() == 1);
    end
  endtask

  task automatic applyStimulus(bit v, logic [7:0] d, logic [1:0] op,
                               bit fl, bit ordy, bit rst);
    reset            = rst;
    bus_if.in_valid  = v;
    bus_if.in_data   = d;
    bus_if.in_op     = op;
    bus_if.flush     = fl;
    bus_if.out_ready = ordy;
  endtask

  task automatic cycle(bit v, logic [7:0] d, logic [1:0] op, bit fl, bit ordy, bit rst);
    @(negedge clk);
    checkOutput();
    if (!rst && !reset && bus_if.out_valid && ordy)
      dut_frame = {dut_frame[39:0], bus_if.out_data};
    applyStimulus(v, d, op, fl, ordy, rst);
    model_step(v, d, op, fl, ordy, rst);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    dut_frame  = '0;
    last_frame = '0;
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);

    // Full window, no backpressure.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 2'b01, 1'b0, 1'b1, 1'b0);
    check("frame1_model", last_frame, 48'h48_00_24_01_08_04);
    drain();
    check("frame1_dut", dut_frame, 48'h48_00_24_01_08_04);

    // Partial window closed by flush.
    cycle(1'b1, 8'h10, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h20, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h30, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0);
    check("frame2_model", last_frame, 48'h03_00_60_10_30_0C);
    drain();
    check("frame2_dut", dut_frame, 48'h03_00_60_10_30_0C);

    // Flush together with a sample of a different op.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h05, 2'b10, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h09, 2'b11, 1'b1, 1'b1, 1'b0);
    check("frame3_model", last_frame, 48'hA4_00_18_05_09_03);
    drain();
    check("frame3_dut", dut_frame, 48'hA4_00_18_05_09_03);

    // Saturating samples.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hFF, 2'b11, 1'b0, 1'b1, 1'b0);
    check("frame4_model", last_frame, 48'hC8_07_F8_FF_FF_FF);
    drain();
    check("frame4_dut", dut_frame, 48'hC8_07_F8_FF_FF_FF);

    // Backpressure at beat 2 with a source holding in_valid.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 2'b01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'hAA, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hAA, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hAA, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("frame5_dut", dut_frame, 48'h48_00_24_01_08_04);
    check("frame5_no_consume", win_data.size(), 0);

    // Reset at beat 3, then an empty flush, then a normal window.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 2'b01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
    #1;
    check("rst_out_valid_now", bus_if.out_valid, 1'b0);
    check("rst_busy_now", bus_if.busy, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + 8'(i)), 2'b10, 1'b0, 1'b1, 1'b0);
    check("frame6_model", last_frame, 48'h88_01_1C_20_27_23);
    drain();
    check("frame6_dut", dut_frame, 48'h88_01_1C_20_27_23);

    // Randomized traffic with occasional flushes, backpressure and resets.
    begin
      logic [1:0] base_op;
      base_op = 2'($urandom_range(3));
      for (int i = 0; i < 4000; i++) begin
        bit         v;
        bit         fl;
        bit         ordy;
        bit         rst;
        logic [7:0] d;
        logic [1:0] op;
        v    = ($urandom_range(3) != 0);
        d    = 8'($urandom);
        op   = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : base_op;
        fl   = ($urandom_range(15) == 0);
        ordy = ($urandom_range(2) != 0);
        rst  = ($urandom_range(499) == 0);
        if ($urandom_range(31) == 0) base_op = 2'($urandom_range(3));
        cycle(v, d, op, fl, ordy, rst);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spu_result_reducer.md
# spu_result_reducer

Downstream reduction stage for the spatial processing unit. It consumes the registered 8-bit result stream (`{ResultHigh, ResultLow}` plus the 2-bit op tag that produced it) one sample per valid/ready handshake. Over a window of 2^LOG2_WIN samples it accumulates sum, min and max. It then emits a 6-byte summary frame over an output valid/ready handshake, for off-chip readout of aggregated raster/vector statistics.

## Interface

**Parameters**
- `LOG2_WIN`, default 3: window size is 2^LOG2_WIN samples. Legal range is 1..4, so the window is 2..16 samples.

**Ports**
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: sample present.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_data` input 8: result byte `{high, low}`.
- `in_op` input 2: op tag of the sample (00 mean, 01 distance, 10 area, 11 tensor).
- `flush` input 1: close the current partial window.
- `out_valid` output 1: summary beat present.
- `out_ready` input 1: downstream accepts the beat.
- `out_data` output 8: summary beat.
- `out_last` output 1: high on beat 5 only.
- `busy` output 1: window non-empty, or a frame is being emitted.

## Operation

**States**
- ACCUM: `in_ready`=1.
- EMIT: `in_ready`=0, `out_valid`=1.

**Accept rule**
- A sample is accepted when `in_valid` and `in_ready` are both high.
- On acceptance:
  - `sum` += `in_data`. `sum` is 16 bits wide; the maximum is 16 × 255 = 4080, so no overflow is possible.
  - `min` = min(`min`, `in_data`) and `max` = max(`max`, `in_data`).
  - `count` += 1. `count` is 5 bits wide.
- The first sample of a window loads `min`, `max` and `op` directly. `op` is latched from the first sample only.
- If a later sample's `in_op` differs from the latched `op`, the sticky `mixed` flag is set.

**Window close**
- ACCUM → EMIT when an acceptance makes `count` == 2^LOG2_WIN.
- ACCUM → EMIT when `flush`=1 and the post-cycle `count` ≥ 1.
- If `flush` coincides with an accepted sample, that sample is included before closing.
- `flush` with an empty window does nothing.
- `flush` during EMIT is ignored; it is not queued.

**Frame** (beat index 0..5, advances on `out_valid` && `out_ready`)
- Beat 0: header `{op[1:0], mixed, count[4:0]}`.
- Beat 1: `sum[15:8]`.
- Beat 2: `sum[7:0]`.
- Beat 3: `min`.
- Beat 4: `max`.
- Beat 5: mean = `sum >> LOG2_WIN`, truncated. The shift is fixed even for partial windows; consumers use `count` to detect a partial window.

**Return to ACCUM**
- When beat 5 is accepted, the block returns to ACCUM and clears `sum`, `count`, `mixed` and the beat index.

**Status and outputs**
- `busy` = (state == EMIT) || (`count` != 0).
- `out_data` and `out_last` are driven from the registered beat index and the frozen accumulators. They are a pure function of state.

## Timing

**Reset values**
- While `reset` is high: state = ACCUM, all accumulators = 0, beat index = 0.
- While `reset` is high: `in_ready`=0, `out_valid`=0, `out_data`=0x00, `out_last`=0, `busy`=0.
- The first cycle after `reset` deasserts has `in_ready`=1.

**Reset mid-frame**
- `reset` asserted during EMIT or ACCUM discards the partial window or frame immediately. No further beats are emitted.

**Latency**
- Closing acceptance or flush at edge N: `out_valid`=1 after edge N, with beat 0 presented in the cycle N..N+1.
- Last beat accepted at edge M: `in_ready`=1 in the cycle following edge M.
- Minimum frame with `out_ready` tied high: 6 cycles. Full-window throughput is 2^LOG2_WIN + 6 cycles per frame.

**Backpressure**
- With `out_ready`=0, `out_data`, `out_last` and `out_valid` hold stable.
- No input is accepted while in EMIT.

**Input handshake**
- `in_ready` does not depend on `in_valid`, `in_data` or `in_op`.
- A source holding `in_valid` during EMIT must keep its data stable.

## Test plan

1. **Full window, no backpressure.** Default LOG2_WIN=3, op=01, samples 1..8, `out_ready`=1 → beats 0x48, 0x00, 0x24, 0x01, 0x08, 0x04. `out_last` is high only on 0x04; `in_ready`=1 the cycle after.
2. **Partial window via flush.** op=00, samples 0x10, 0x20, 0x30, then `flush` → beats 0x03, 0x00, 0x60, 0x10, 0x30, 0x0C.
3. **Flush coincident with a sample, plus mixed ops.**
   - Op 10, samples 0x05 ×3.
   - Then op 11, sample 0x09, with `flush` in the same cycle.
   - Required response: beats 0xA4, 0x00, 0x18, 0x05, 0x09, 0x03.
4. **Saturating values.** 8 samples of 0xFF, op=11 → beats 0xC8, 0x07, 0xF8, 0xFF, 0xFF, 0xFF.
5. **Backpressure during EMIT.** Hold `out_ready`=0 for 5 cycles at beat 2, with `in_valid`=1 throughout.
   - `out_data` holds the beat-2 value.
   - `in_ready` stays 0 and no sample is consumed.
   - The frame resumes intact when `out_ready` returns high.
6. **Reset during EMIT, then empty flush.**
   - Assert `reset` at beat 3: `out_valid`=0 immediately, `busy`=0.
   - After release, a `flush` with no samples produces no frame.
   - A subsequent 8-sample window emits normally.
